uart_receiver: RTL and testbench



---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_baud_tick.sv | 16 +
 rtl/uart_receiver.sv | 111 +++++++++++
 tb/tb_uart_receiver.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receiver states, oversampling constants and the baud divisor helper.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle tick every DIV clocks; clr holds the divider at phase zero.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge sysclk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled 8N1 UART receive stage with valid/ack handshake, framing and overrun flags.
// Define UART_RX_PARITY_EN for 8E1 framing with a one-cycle parity_error pulse.
module uart_receiver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       uart_rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_error
`endif
);
  import uart_pkg::*;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SC_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SC_MID = SW'(MID_SAMPLE);
  state_t state;
  logic [1:0] sync;
  logic [SW-1:0] sc;
  logic [2:0] bc;
  logic [7:0] shreg;
  logic rx_s, tick, mid, last, stop_hit, par_bad, good;
  assign rx_s = sync[1];
  assign busy = state != IDLE;
  assign mid = tick && sc == SC_MID;
  assign last = tick && sc == SC_LAST;
  assign stop_hit = enable && state == STOP && last;
  assign good = stop_hit && rx_s && !par_bad;
  uart_baud_tick #(.DIV(baud_div(CLK_FREQ, BAUD))) u_tick (
    .sysclk (sysclk),
    .reset_n(reset_n),
    .clr    (state == IDLE),
    .tick   (tick)
  );
  always_ff @(posedge sysclk or negedge reset_n)
    if (!reset_n) sync <= 2'b11;
    else sync <= {sync[0], uart_rx};
  // Leaving STOP at the mid-stop sample lets a back-to-back start bit be caught.
  always_ff @(posedge sysclk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      sc    <= '0;
      bc    <= '0;
      shreg <= '0;
    end else if (busy && !enable) state <= IDLE;
    else
      case (state)
        IDLE: if (enable && !rx_s) begin
          sc    <= '0;
          state <= START;
        end
        START: if (tick) begin
          sc <= mid ? '0 : sc + 1'b1;
          bc <= '0;
          if (mid) state <= rx_s ? IDLE : DATA;
        end
        DATA: if (tick) begin
          sc <= sc + 1'b1;
          if (last) begin
            shreg <= {rx_s, shreg[7:1]};
            bc    <= bc + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (&bc) state <= PARITY;
`else
            if (&bc) state <= STOP;
`endif
          end
        end
        PARITY, STOP: if (tick) begin
          sc <= sc + 1'b1;
          if (last) state <= state == STOP ? IDLE : STOP;
        end
        default: state <= IDLE;
      endcase
  always_ff @(posedge sysclk or negedge reset_n)
    if (!reset_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= stop_hit && !rx_s;
      rx_valid    <= good || (rx_valid && !rx_ack);
      overrun     <= (good && rx_valid && !rx_ack) || (overrun && !rx_ack);
      if (good) rx_data <= shreg;
    end
`ifdef UART_RX_PARITY_EN
  logic par;
  assign par_bad = ^{shreg, par};
  always_ff @(posedge sysclk or negedge reset_n)
    if (!reset_n) begin
      par          <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      if (state == PARITY && last) par <= rx_s;
      parity_error <= stop_hit && rx_s && par_bad;
    end
`else
  assign par_bad = 1'b0;
`endif
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and random frames checked each cycle against a frame-level timing model.
module tb_uart_receiver;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD = 10_000;
  localparam int DIV = 10;
  localparam int BITC = 160;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
  localparam int LAT_LIT = 1683;
`else
  localparam int NB = 9;
  localparam int LAT_LIT = 1523;
`endif
  // 2 sync flops + 1 edge to leave IDLE, then 8 ticks to mid-start and 16 per later bit up to mid-stop
  localparam int LAT = 3 + DIV * (8 + 16 * NB);
  logic sysclk = 0, reset_n = 0, enable = 1, uart_rx = 1, rx_ack = 0;
  logic [7:0] rx_data;
  logic rx_valid, frame_error, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic parity_error;
`endif
  uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .enable(enable), .uart_rx(uart_rx), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_error(frame_error), .overrun(overrun), .busy(busy)
`ifdef UART_RX_PARITY_EN
    , .parity_error(parity_error)
`endif
  );
  always #5 sysclk = ~sysclk;
  int unsigned cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;
  // kind: 0 good byte, 1 bad stop, 2 bad parity, 3 false start (no output)
  typedef struct {
    int unsigned start_at;
    int unsigned end_at;
    logic [7:0] d;
    int kind;
  } frm_t;
  frm_t q[$];
  int vectors = 0, miscompares = 0, fe_cnt = 0, pe_cnt = 0;
  logic [7:0] m_data = '0;
  logic m_valid = 0, m_ov = 0, m_fe = 0, m_pe = 0, m_busy = 0, v_prev = 0;
  int unsigned v_rise = 0, last_e0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial forever begin : model
    int unsigned n;
    frm_t f;
    bit good;
    @(posedge sysclk or negedge reset_n);
    if (!reset_n) begin
      m_data = '0; m_valid = 0; m_ov = 0; m_fe = 0; m_pe = 0; m_busy = 0;
      q.delete();
    end else begin
      n = cyc + 1;
      good = 0;
      m_fe = 0;
      m_pe = 0;
      if (q.size() > 0 && q[0].start_at == n) m_busy = 1;
      if (m_busy && !enable) begin
        m_busy = 0;
        void'(q.pop_front());
      end else if (m_busy && q.size() > 0 && q[0].end_at == n) begin
        f = q.pop_front();
        m_busy = 0;
        good = f.kind == 0;
        m_fe = f.kind == 1;
        m_pe = f.kind == 2;
        if (good) m_data = f.d;
      end
      if (good) begin
        if (m_valid && !rx_ack) m_ov = 1;
        else if (rx_ack) m_ov = 0;
        m_valid = 1;
      end else if (rx_ack && m_valid) begin
        m_valid = 0;
        m_ov = 0;
      end
    end
  end

  initial forever begin
    @(negedge sysclk);
    chk("rx_data", rx_data, m_data);
    chk("rx_valid", rx_valid, m_valid);
    chk("overrun", overrun, m_ov);
    chk("frame_error", frame_error, m_fe);
    chk("busy", busy, m_busy);
`ifdef UART_RX_PARITY_EN
    chk("parity_error", parity_error, m_pe);
    if (parity_error === 1'b1) pe_cnt++;
`endif
    if (frame_error === 1'b1) fe_cnt++;
    if (rx_valid === 1'b1 && !v_prev) v_rise = cyc;
    v_prev = rx_valid;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic ack_now();
    rx_ack = 1;
    idle(1);
    rx_ack = 0;
  endtask

  task automatic ack_at(input int unsigned x);
    while (cyc < x - 1) idle(1);
    ack_now();
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_bad, input bit par_bad);
    logic [10:0] bits;
    int unsigned e0, end_at;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9] = (^d) ^ par_bad;
    bits[10] = !stop_bad;
`else
    bits[9] = !stop_bad;
`endif
    idle(1);
    e0 = cyc;
    last_e0 = e0;
    end_at = e0 + LAT;
    q.push_back(frm_t'{e0 + 3, end_at, d, stop_bad ? 1 : (par_bad ? 2 : 0)});
    // a low stop bit still looks like a start bit to the now idle receiver
    if (stop_bad) q.push_back(frm_t'{end_at + 1, end_at + 1 + 8 * DIV, 8'h00, 3});
    for (int i = 0; i <= NB; i++) begin
      uart_rx = bits[i];
      idle(BITC);
    end
    uart_rx = 1;
  endtask

  task automatic glitch(input int len);
    idle(1);
    uart_rx = 0;
    q.push_back(frm_t'{cyc + 3, cyc + 3 + 8 * DIV, 8'h00, 3});
    idle(len);
    uart_rx = 1;
  endtask

  initial begin
    logic [7:0] d;
    bit sb, pb;
    int r;
    idle(4);
    chk("reset rx_data", rx_data, 8'h00);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset overrun", overrun, 0);
    reset_n = 1;
    idle(5);
    send_frame(8'hA5, 0, 0);
    chk("a5 data", rx_data, 8'hA5);
    chk("a5 valid", rx_valid, 1);
    chk("a5 latency", v_rise - last_e0, LAT_LIT);
    chk("a5 frame_error", fe_cnt, 0);
    ack_now();
    glitch(40);
    idle(200);
    chk("glitch valid", rx_valid, 0);
    chk("glitch frame_error", fe_cnt, 0);
    chk("glitch overrun", overrun, 0);
    send_frame(8'h3C, 1, 0);
    idle(200);
    chk("badstop frame_error count", fe_cnt, 1);
    chk("badstop data kept", rx_data, 8'hA5);
    chk("badstop valid", rx_valid, 0);
    send_frame(8'h11, 0, 0);
    send_frame(8'h22, 0, 0);
    chk("b2b data", rx_data, 8'h22);
    chk("b2b overrun", overrun, 1);
    ack_now();
    chk("ack valid", rx_valid, 0);
    chk("ack overrun", overrun, 0);
    send_frame(8'h44, 0, 0);
    fork
      send_frame(8'h55, 0, 0);
      begin
        @(posedge sysclk);
        #2;
        ack_at(last_e0 + LAT);
      end
    join
    chk("sameack valid", rx_valid, 1);
    chk("sameack data", rx_data, 8'h55);
    chk("sameack overrun", overrun, 0);
    fork
      send_frame(8'hFF, 0, 0);
      begin
        idle(600);
        reset_n = 0;
        idle(3);
        reset_n = 1;
      end
    join
    chk("abort data", rx_data, 8'h00);
    chk("abort valid", rx_valid, 0);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h0F, 0, 1);
    chk("parity pulse count", pe_cnt, 1);
    chk("parity valid", rx_valid, 0);
`endif
    send_frame(8'h0F, 0, 0);
    chk("after reset data", rx_data, 8'h0F);
    chk("after reset valid", rx_valid, 1);
    ack_now();
    fork
      send_frame(8'h96, 0, 0);
      begin
        idle(700);
        enable = 0;
        idle(2);
        chk("disable busy", busy, 0);
      end
    join
    chk("disable data", rx_data, 8'h0F);
    chk("disable valid", rx_valid, 0);
    enable = 1;
    idle(10);
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      r = int'($urandom_range(0, 7));
      sb = r == 0;
      pb = 0;
`ifdef UART_RX_PARITY_EN
      pb = r == 1;
`endif
      fork
        send_frame(d, sb, pb);
        begin
          if ($urandom_range(0, 1) == 1) begin
            idle(int'($urandom_range(1, 1700)));
            ack_now();
          end
        end
      join
      if (sb) idle(100 + int'($urandom_range(0, 300)));
      else if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 300)));
    end
    idle(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
